// File: rtl/memory_controller_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
package memory_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        STORE
    } mc_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd3;

    localparam logic [1:0] IO_HI_DEF = 2'b11;

    typedef struct packed {
        logic        r_nw;
        logic        sign;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } lsb_req_t;

    function automatic logic [2:0] nbytes(input logic [1:0] size);
        return (size == SZ_W) ? 3'd4 : {1'b0, size} + 3'd1;
    endfunction

    function automatic logic [31:0] extend(
        input logic [31:0] data,
        input logic [1:0]  size,
        input logic        sign
    );
        logic [31:0] r;
        case (size)
            SZ_B:    r = {{24{sign & data[7]}}, data[7:0]};
            SZ_H:    r = {{16{sign & data[15]}}, data[15:0]};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/memory_controller.sv
// Arbitrates IF and LSB onto the byte-wide RAM/IO bus, serialising
// multi-byte accesses and assembling load data.
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter logic [1:0] IO_HI = IO_HI_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        mc_flush,
    input  logic        if_flag,
    input  logic [31:0] if_addr,
    output logic        inst_rdy,
    output logic [31:0] inst,
    input  logic        lsb_flag,
    input  logic        lsb_r_nw,
    input  logic        load_sign,
    input  logic [1:0]  data_size_to_mc,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_write,
    output logic        lsb_enable,
    output logic        data_rdy,
    output logic [31:0] data_read,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    mc_state_t   state, state_nx;
    logic [2:0]  k, k_nx;
    lsb_req_t    slot;
    logic        slot_full;
    logic [31:0] fetch_addr;
    logic [31:0] asm_q, asm_nx;
    logic [31:0] inst_q, data_q;
    logic        inst_rdy_q, data_rdy_q;
    logic        fetch_go, done_i, done_l, done_s;
    logic        capture, io_stall;
    logic [2:0]  n_bytes;
    logic [31:0] base;
    logic [1:0]  cap_idx;

    assign n_bytes  = (state == FETCH) ? 3'd4 : nbytes(slot.size);
    assign base     = (state == FETCH) ? fetch_addr : slot.addr;
    assign io_stall = (state == STORE) && (slot.addr[17:16] == IO_HI)
                      && io_buffer_full;
    assign capture  = ((state == FETCH) || (state == LOAD)) && (k != 3'd0);
    assign cap_idx  = 2'(k - 3'd1);

    // Byte k-1 arrives in cycle k; merge it into the assembly word.
    always_comb begin
        asm_nx = asm_q;
        asm_nx[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        fetch_go = 1'b0;
        done_i   = 1'b0;
        done_l   = 1'b0;
        done_s   = 1'b0;
        unique case (state)
            IDLE: begin
                k_nx = 3'd0;
                // The slot stays full through its own data_rdy cycle.
                if (slot_full && !data_rdy_q) begin
                    state_nx = slot.r_nw ? LOAD : STORE;
                end else if (!lsb_flag && if_flag && !inst_rdy_q) begin
                    state_nx = FETCH;
                    fetch_go = 1'b1;
                end
            end
            FETCH, LOAD: begin
                k_nx = k + 3'd1;
                if ((state == FETCH) && mc_flush) begin
                    state_nx = IDLE;
                    k_nx     = 3'd0;
                end else if (k == n_bytes) begin
                    state_nx = IDLE;
                    k_nx     = 3'd0;
                    done_i   = (state == FETCH);
                    done_l   = (state == LOAD);
                end
            end
            STORE: begin
                if (!io_stall) begin
                    if (k == n_bytes - 3'd1) begin
                        state_nx = IDLE;
                        k_nx     = 3'd0;
                        done_s   = 1'b1;
                    end else begin
                        k_nx = k + 3'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            k          <= 3'd0;
            slot       <= '0;
            slot_full  <= 1'b0;
            fetch_addr <= 32'd0;
            asm_q      <= 32'd0;
            inst_q     <= 32'd0;
            data_q     <= 32'd0;
            inst_rdy_q <= 1'b0;
            data_rdy_q <= 1'b0;
        end else if (rdy) begin
            state      <= state_nx;
            k          <= k_nx;
            inst_rdy_q <= done_i;
            data_rdy_q <= done_l | done_s;
            if (fetch_go) fetch_addr <= if_addr;
            if (capture) asm_q <= asm_nx;
            if (done_i) inst_q <= asm_nx;
            if (done_l) data_q <= extend(asm_nx, slot.size, slot.sign);
            if (lsb_flag) begin
                slot_full  <= 1'b1;
                slot.r_nw  <= lsb_r_nw;
                slot.sign  <= load_sign;
                slot.size  <= data_size_to_mc;
                slot.addr  <= data_addr;
                slot.data  <= data_write;
            end else if (data_rdy_q) begin
                slot_full <= 1'b0;
            end
        end
    end

    assign mem_a      = (state == IDLE) ? 32'd0 : base + {29'd0, k};
    assign mem_dout   = (state == STORE) ? slot.data[{k[1:0], 3'b000} +: 8]
                                         : 8'd0;
    assign mem_wr     = rdy && (state == STORE) && !io_stall;
    assign lsb_enable = !slot_full;
    assign inst_rdy   = inst_rdy_q && !mc_flush;
    assign inst       = inst_q;
    assign data_rdy   = data_rdy_q;
    assign data_read  = data_q;

endmodule
